sonic_sprite_fetch: RTL and testbench

Pixel-fetch stage that feeds the 16-entry sprite palette lookup. For each VGA pixel it decides whether the pixel falls inside the Sonic sprite, computes the sprite-ROM address (animation frame, row, column, optional horizontal flip), captures the returned 4-bit colour index and emits it with an opaque flag; the index then drives the palette. Sprite position, flip and animation frame are latched once per frame at vsync, so the sprite never tears mid-frame.

---
 rtl/sprite_pkg.sv | 25 ++
 rtl/sprite_anim_ctrl.sv | 71 +++++++
 rtl/sonic_sprite_fetch.sv | 124 ++++++++++++
 tb/tb_sonic_sprite_fetch.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared defaults and types for the Sonic sprite fetch stage.
package sprite_pkg;

  localparam int unsigned SPRITE_W    = 32;
  localparam int unsigned SPRITE_H    = 40;
  localparam int unsigned NUM_FRAMES  = 4;
  localparam int unsigned FRAME_TICKS = 8;
  localparam int unsigned ADDR_W      = 13;

  // Palette index 0 is the see-through colour.
  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

  // Per-frame sprite placement, captured at the vsync falling edge.
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       flip;
  } sprite_cfg_t;

  // Counter width that stays legal for a count of 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Frame-start detection, once-per-frame sprite placement latch and
// animation tick/frame counters.
module sprite_anim_ctrl #(
  parameter int unsigned NUM_FRAMES  = sprite_pkg::NUM_FRAMES,
  parameter int unsigned FRAME_TICKS = sprite_pkg::FRAME_TICKS,
  parameter int unsigned FRAME_W     = sprite_pkg::cnt_width(sprite_pkg::NUM_FRAMES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync,
  input  logic               anim_en,
  input  logic [9:0]         sprite_x,
  input  logic [9:0]         sprite_y,
  input  logic               flip_h,
  output logic [9:0]         sx,
  output logic [9:0]         sy,
  output logic               flip,
  output logic [FRAME_W-1:0] frame
);
  import sprite_pkg::*;

  localparam int unsigned TICK_W = cnt_width(FRAME_TICKS);

  logic               vsync_q, vsync_d;
  sprite_cfg_t        cfg_q, cfg_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               frame_start;

  // Next-state: latch placement and step the animation on vsync falling edge.
  always_comb begin
    frame_start = vsync_q & ~vsync;
    vsync_d     = vsync;
    cfg_d       = cfg_q;
    tick_d      = tick_q;
    frame_d     = frame_q;
    if (frame_start) begin
      cfg_d = '{x: sprite_x, y: sprite_y, flip: flip_h};
      if (!anim_en) begin
        tick_d  = '0;
        frame_d = '0;
      end else if (tick_q == TICK_W'(FRAME_TICKS - 1)) begin
        tick_d  = '0;
        frame_d = (frame_q == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b0;
      cfg_q   <= '0;
      tick_q  <= '0;
      frame_q <= '0;
    end else begin
      vsync_q <= vsync_d;
      cfg_q   <= cfg_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
    end
  end

  assign sx    = cfg_q.x;
  assign sy    = cfg_q.y;
  assign flip  = cfg_q.flip;
  assign frame = frame_q;

endmodule

// File: rtl/sonic_sprite_fetch.sv
// Three-stage pixel fetch: hit test and ROM address, ROM read, then
// opaque/index output. One pixel per clock.
module sonic_sprite_fetch #(
  parameter int unsigned SPRITE_W    = sprite_pkg::SPRITE_W,
  parameter int unsigned SPRITE_H    = sprite_pkg::SPRITE_H,
  parameter int unsigned NUM_FRAMES  = sprite_pkg::NUM_FRAMES,
  parameter int unsigned FRAME_TICKS = sprite_pkg::FRAME_TICKS,
  parameter int unsigned ADDR_W      = sprite_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              vsync,
  input  logic              blank,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic              flip_h,
  input  logic              anim_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pixel_index,
  output logic              pixel_opaque,
  output logic              blank_d
);
  import sprite_pkg::*;

  localparam int unsigned FRAME_W = cnt_width(NUM_FRAMES);

  logic [9:0]         sx, sy;
  logic               flip;
  logic [FRAME_W-1:0] frame;

  sprite_anim_ctrl #(
    .NUM_FRAMES  (NUM_FRAMES),
    .FRAME_TICKS (FRAME_TICKS),
    .FRAME_W     (FRAME_W)
  ) u_anim (
    .clk      (Clk),
    .rst      (Reset),
    .vsync    (vsync),
    .anim_en  (anim_en),
    .sprite_x (sprite_x),
    .sprite_y (sprite_y),
    .flip_h   (flip_h),
    .sx       (sx),
    .sy       (sy),
    .flip     (flip),
    .frame    (frame)
  );

  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              hit1_q, hit1_d, blank1_q, blank1_d;
  logic              hit2_q, hit2_d, blank2_q, blank2_d;
  logic [3:0]        pixel_index_q, pixel_index_d;
  logic              pixel_opaque_q, pixel_opaque_d;
  logic              blank3_q, blank3_d;

  logic [10:0] x11, y11, sx11, sy11, dx, dy, col;
  logic        in_x, in_y;

  // Stage 1: window test in 11 bits so a sprite near column 1023 never wraps.
  always_comb begin
    x11        = {1'b0, DrawX};
    y11        = {1'b0, DrawY};
    sx11       = {1'b0, sx};
    sy11       = {1'b0, sy};
    in_x       = (x11 >= sx11) && (x11 < sx11 + 11'(SPRITE_W));
    in_y       = (y11 >= sy11) && (y11 < sy11 + 11'(SPRITE_H));
    hit1_d     = blank & in_x & in_y;
    blank1_d   = blank;
    dx         = x11 - sx11;
    dy         = y11 - sy11;
    col        = flip ? (11'(SPRITE_W - 1) - dx) : dx;
    rom_addr_d = '0;
    if (hit1_d) begin
      rom_addr_d = ADDR_W'(frame) * ADDR_W'(SPRITE_W * SPRITE_H)
                 + ADDR_W'(dy) * ADDR_W'(SPRITE_W)
                 + ADDR_W'(col);
    end
  end

  // Stage 2: carry hit/blank alongside the ROM read.
  always_comb begin
    hit2_d   = hit1_q;
    blank2_d = blank1_q;
  end

  // Stage 3: transparent index or a miss yields a non-drawn pixel.
  always_comb begin
    pixel_opaque_d = hit2_q && (rom_data != TRANSPARENT_IDX);
    pixel_index_d  = pixel_opaque_d ? rom_data : TRANSPARENT_IDX;
    blank3_d       = blank2_q;
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr_q     <= '0;
      hit1_q         <= 1'b0;
      blank1_q       <= 1'b0;
      hit2_q         <= 1'b0;
      blank2_q       <= 1'b0;
      pixel_index_q  <= '0;
      pixel_opaque_q <= 1'b0;
      blank3_q       <= 1'b0;
    end else begin
      rom_addr_q     <= rom_addr_d;
      hit1_q         <= hit1_d;
      blank1_q       <= blank1_d;
      hit2_q         <= hit2_d;
      blank2_q       <= blank2_d;
      pixel_index_q  <= pixel_index_d;
      pixel_opaque_q <= pixel_opaque_d;
      blank3_q       <= blank3_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign pixel_index  = pixel_index_q;
  assign pixel_opaque = pixel_opaque_q;
  assign blank_d      = blank3_q;

endmodule

// File: tb/tb_sonic_sprite_fetch.sv
// Bench for sonic_sprite_fetch: directed scenarios plus a randomized stream
// checked against a pixel-level model of the sprite rules.
module tb_sonic_sprite_fetch;

  localparam int SW = 32;
  localparam int SH = 40;
  localparam int NF = 4;
  localparam int FT = 8;
  localparam int NRAND = 600;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        vsync = 1'b1;
  logic        blank = 1'b0;
  logic        flip_h = 1'b0;
  logic        anim_en = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, sprite_x = '0, sprite_y = '0;
  logic [12:0] rom_addr;
  logic [3:0]  rom_data;
  logic [3:0]  pixel_index;
  logic        pixel_opaque, blank_d;

  logic [3:0]  rom [0:8191];

  int n_checks = 0;
  int n_pass   = 0;

  int m_sx, m_sy, m_flip, m_tick, m_frame;

  sonic_sprite_fetch dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .vsync        (vsync),
    .blank        (blank),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .flip_h       (flip_h),
    .anim_en      (anim_en),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .pixel_index  (pixel_index),
    .pixel_opaque (pixel_opaque),
    .blank_d      (blank_d)
  );

  always #5 Clk = ~Clk;

  // Sprite ROM with a one-cycle registered read.
  always @(posedge Clk) rom_data <= rom[rom_addr];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic bit model_hit(int x, int y, int b);
    return (b != 0) && (x >= m_sx) && (x < m_sx + SW) && (y >= m_sy) && (y < m_sy + SH);
  endfunction

  function automatic int model_addr(int x, int y, int b);
    int c;
    if (!model_hit(x, y, b)) return 0;
    c = (m_flip != 0) ? (SW - 1 - (x - m_sx)) : (x - m_sx);
    return m_frame * SW * SH + (y - m_sy) * SW + c;
  endfunction

  function automatic int model_index(int x, int y, int b);
    int a;
    a = model_addr(x, y, b);
    if (model_hit(x, y, b) && rom[a] != 4'h0) return int'(rom[a]);
    return 0;
  endfunction

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_flip = 0; m_tick = 0; m_frame = 0;
  endtask

  task automatic model_frame_start(int sx, int sy, int fl, int an);
    m_sx = sx; m_sy = sy; m_flip = fl;
    if (an == 0) begin
      m_tick = 0; m_frame = 0;
    end else begin
      m_tick = m_tick + 1;
      if (m_tick == FT) begin
        m_tick  = 0;
        m_frame = (m_frame + 1) % NF;
      end
    end
  endtask

  task automatic vsync_pulse(int sx, int sy, int fl, int an);
    blank = 0; DrawX = '0; DrawY = '0;
    sprite_x = 10'(sx); sprite_y = 10'(sy); flip_h = fl[0]; anim_en = an[0];
    vsync = 1'b0;
    step();
    model_frame_start(sx, sy, fl, an);
    vsync = 1'b1;
    step();
  endtask

  // Issues one pixel, then idles; returns stage-1 address and stage-3 outputs.
  task automatic drive_pixel(input int x, input int y, input int b,
                             output logic [12:0] a, output logic [3:0] idx,
                             output logic op, output logic bd);
    DrawX = 10'(x); DrawY = 10'(y); blank = b[0];
    step();
    a = rom_addr;
    blank = 1'b0; DrawX = '0; DrawY = '0;
    step();
    step();
    idx = pixel_index; op = pixel_opaque; bd = blank_d;
  endtask

  task automatic test_reset();
    vsync_pulse(100, 50, 0, 1);
    rom[330] = 4'h5;
    DrawX = 10'd110; DrawY = 10'd60; blank = 1'b1;
    step(); step(); step();
    n_checks++;
    if (pixel_index !== 4'h5) $display("FAIL reset_pre_index got %0d exp 5", pixel_index);
    else n_pass++;
    #2 Reset = 1'b1;
    #1;
    n_checks++;
    if (rom_addr !== 13'd0 || pixel_index !== 4'd0 || pixel_opaque !== 1'b0 || blank_d !== 1'b0)
      $display("FAIL reset_async_clear got addr=%0d idx=%0d op=%0b bd=%0b exp all 0",
               rom_addr, pixel_index, pixel_opaque, blank_d);
    else n_pass++;
    step(); step();
    Reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (blank_d !== (i == 2) || pixel_opaque !== 1'b0)
        $display("FAIL reset_refill cyc=%0d got bd=%0b op=%0b exp bd=%0b op=0",
                 i, blank_d, pixel_opaque, (i == 2));
      else n_pass++;
    end
    begin
      logic [12:0] a; logic [3:0] idx; logic op, bd;
      drive_pixel(5, 7, 1, a, idx, op, bd);
      n_checks++;
      if (a !== 13'd229) $display("FAIL reset_pos_cleared addr got %0d exp 229", a);
      else n_pass++;
      n_checks++;
      if (idx !== 4'(model_index(5, 7, 1)) || bd !== 1'b1)
        $display("FAIL reset_first_pixel got idx=%0d bd=%0b exp idx=%0d bd=1",
                 idx, bd, model_index(5, 7, 1));
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    int px[6] = '{100, 131, 132, 99, 100, 115};
    int py[6] = '{50, 89, 89, 50, 90, 70};
    logic [12:0] a; logic [3:0] idx; logic op, bd;
    vsync_pulse(100, 50, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive_pixel(px[i], py[i], 1, a, idx, op, bd);
      n_checks++;
      if (a !== 13'(model_addr(px[i], py[i], 1)))
        $display("FAIL basic_addr (%0d,%0d) got %0d exp %0d", px[i], py[i], a, model_addr(px[i], py[i], 1));
      else n_pass++;
      n_checks++;
      if (idx !== 4'(model_index(px[i], py[i], 1)) || op !== (model_index(px[i], py[i], 1) != 0))
        $display("FAIL basic_out (%0d,%0d) got idx=%0d op=%0b exp idx=%0d",
                 px[i], py[i], idx, op, model_index(px[i], py[i], 1));
      else n_pass++;
    end
    drive_pixel(131, 89, 1, a, idx, op, bd);
    n_checks++;
    if (a !== 13'd1279) $display("FAIL basic_corner got %0d exp 1279", a);
    else n_pass++;
  endtask

  task automatic test_flip();
    int px[3] = '{100, 131, 120};
    int py[3] = '{50, 50, 75};
    logic [12:0] a; logic [3:0] idx; logic op, bd;
    vsync_pulse(100, 50, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive_pixel(px[i], py[i], 1, a, idx, op, bd);
      n_checks++;
      if (a !== 13'(model_addr(px[i], py[i], 1)))
        $display("FAIL flip_addr (%0d,%0d) got %0d exp %0d", px[i], py[i], a, model_addr(px[i], py[i], 1));
      else n_pass++;
    end
    drive_pixel(100, 50, 1, a, idx, op, bd);
    n_checks++;
    if (a !== 13'd31) $display("FAIL flip_left_edge got %0d exp 31", a);
    else n_pass++;
  endtask

  task automatic test_anim();
    int edges[4] = '{8, 24, 8, 1};
    int en[4]    = '{1, 1, 1, 0};
    logic [12:0] a; logic [3:0] idx; logic op, bd;
    for (int s = 0; s < 4; s++) begin
      for (int e = 0; e < edges[s]; e++) vsync_pulse(100, 50, 0, en[s]);
      drive_pixel(100, 50, 1, a, idx, op, bd);
      n_checks++;
      if (a !== 13'(model_addr(100, 50, 1)))
        $display("FAIL anim_step%0d addr got %0d exp %0d", s, a, model_addr(100, 50, 1));
      else n_pass++;
    end
  endtask

  task automatic test_opaque();
    logic [12:0] a; logic [3:0] idx; logic op, bd;
    vsync_pulse(100, 50, 0, 0);
    rom[165] = 4'h0;
    drive_pixel(105, 55, 1, a, idx, op, bd);
    n_checks++;
    if (op !== 1'b0 || idx !== 4'h0) $display("FAIL opaque_zero got op=%0b idx=%0d exp 0/0", op, idx);
    else n_pass++;
    rom[165] = 4'h3;
    DrawX = 10'd105; DrawY = 10'd55; blank = 1'b1;
    step();
    blank = 1'b0; DrawX = '0; DrawY = '0;
    step();
    n_checks++;
    if (pixel_opaque !== 1'b0) $display("FAIL opaque_early got op=%0b exp 0 at N+2", pixel_opaque);
    else n_pass++;
    step();
    n_checks++;
    if (pixel_opaque !== 1'b1 || pixel_index !== 4'h3)
      $display("FAIL opaque_three got op=%0b idx=%0d exp 1/3", pixel_opaque, pixel_index);
    else n_pass++;
    step();
    n_checks++;
    if (pixel_opaque !== 1'b0) $display("FAIL opaque_late got op=%0b exp 0 at N+4", pixel_opaque);
    else n_pass++;
    drive_pixel(105, 55, 0, a, idx, op, bd);
    n_checks++;
    if (a !== 13'd0 || op !== 1'b0 || bd !== 1'b0)
      $display("FAIL opaque_blanked got addr=%0d op=%0b bd=%0b exp 0/0/0", a, op, bd);
    else n_pass++;
  endtask

  task automatic test_edge();
    int px[4] = '{1000, 1023, 3, 1023};
    int py[4] = '{100, 100, 100, 139};
    logic [12:0] a; logic [3:0] idx; logic op, bd;
    vsync_pulse(1000, 100, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive_pixel(px[i], py[i], 1, a, idx, op, bd);
      n_checks++;
      if (a !== 13'(model_addr(px[i], py[i], 1)))
        $display("FAIL edge_addr (%0d,%0d) got %0d exp %0d", px[i], py[i], a, model_addr(px[i], py[i], 1));
      else n_pass++;
    end
    sprite_x = 10'd200;
    drive_pixel(1010, 100, 1, a, idx, op, bd);
    n_checks++;
    if (a !== 13'd10) $display("FAIL edge_midframe_hold got %0d exp 10", a);
    else n_pass++;
    vsync_pulse(200, 100, 0, 0);
    drive_pixel(210, 100, 1, a, idx, op, bd);
    n_checks++;
    if (a !== 13'd10) $display("FAIL edge_new_pos got %0d exp 10", a);
    else n_pass++;
  endtask

  task automatic test_random_stream();
    int ea[NRAND], ei[NRAND], eb[NRAND];
    int prev_vs, vs, x, y, b, sx, sy, fl, an;
    prev_vs = 1;
    for (int k = 0; k < NRAND; k++) begin
      vs = (prev_vs == 1 && $urandom_range(0, 19) == 0) ? 0 : 1;
      sx = $urandom_range(0, 1023); sy = $urandom_range(0, 479);
      fl = $urandom_range(0, 1);    an = ($urandom_range(0, 7) != 0) ? 1 : 0;
      if ($urandom_range(0, 3) != 0) begin
        x = m_sx + $urandom_range(0, SW + 7) - 4;
        y = m_sy + $urandom_range(0, SH + 7) - 4;
      end else begin
        x = $urandom_range(0, 1023); y = $urandom_range(0, 1023);
      end
      if (x < 0) x = 0;
      if (x > 1023) x = 1023;
      if (y < 0) y = 0;
      if (y > 1023) y = 1023;
      b = ($urandom_range(0, 5) != 0) ? 1 : 0;
      ea[k] = model_addr(x, y, b);
      ei[k] = model_index(x, y, b);
      eb[k] = b;
      if (vs == 0 && prev_vs == 1) model_frame_start(sx, sy, fl, an);
      prev_vs = vs;
      vsync = vs[0]; sprite_x = 10'(sx); sprite_y = 10'(sy); flip_h = fl[0]; anim_en = an[0];
      DrawX = 10'(x); DrawY = 10'(y); blank = b[0];
      step();
      n_checks++;
      if (rom_addr !== 13'(ea[k]))
        $display("FAIL rand_addr k=%0d got %0d exp %0d", k, rom_addr, ea[k]);
      else n_pass++;
      if (k >= 2) begin
        n_checks++;
        if (pixel_index !== 4'(ei[k-2]) || pixel_opaque !== (ei[k-2] != 0) || blank_d !== eb[k-2][0])
          $display("FAIL rand_out k=%0d got idx=%0d op=%0b bd=%0b exp idx=%0d bd=%0d",
                   k - 2, pixel_index, pixel_opaque, blank_d, ei[k-2], eb[k-2]);
        else n_pass++;
      end
    end
    vsync = 1'b1; blank = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) rom[i] = 4'($urandom_range(0, 15));
    model_reset();
    Reset = 1'b1;
    repeat (3) step();
    Reset = 1'b0;
    step();
    test_reset();
    test_basic();
    test_flip();
    test_anim();
    test_opaque();
    test_edge();
    test_random_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
